// File: rtl/cache_arbiter.sv
// Two-master round-robin arbiter in front of a single-port cache.
// One request is in flight at a time; every output is driven from a register.
module cache_arbiter #(
    parameter int ADDRESS_BITWIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m0_req,
    input  logic                        m1_req,
    input  logic [ADDRESS_BITWIDTH-1:0] m0_address,
    input  logic [ADDRESS_BITWIDTH-1:0] m1_address,
    input  logic [31:0]                 m0_data_in,
    input  logic [31:0]                 m1_data_in,
    input  logic [3:0]                  m0_write_enable,
    input  logic [3:0]                  m1_write_enable,
    output logic [31:0]                 m0_data_out,
    output logic [31:0]                 m1_data_out,
    output logic                        m0_done,
    output logic                        m1_done,
    output logic [ADDRESS_BITWIDTH-1:0] c_address,
    output logic [31:0]                 c_data_in,
    output logic [3:0]                  c_write_enable,
    input  logic [31:0]                 c_data_out,
    input  logic                        c_data_out_ready,
    input  logic                        c_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_reg;
    logic   last_grant_reg;
    logic   grant_reg;
    logic   next_grant;
    logic   complete;

    // Contention goes to the master not served last; otherwise to whoever asks.
    always_comb begin
        next_grant = m1_req;
        if (m0_req && m1_req) begin
            next_grant = ~last_grant_reg;
        end
    end

    // A non-zero enable pattern marks the in-flight request as a write.
    always_comb begin
        complete = 1'b0;
        if (!c_busy) begin
            complete = (c_write_enable != 4'b0000) || c_data_out_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            c_address      <= '0;
            c_data_in      <= '0;
            c_write_enable <= '0;
            m0_data_out    <= '0;
            m1_data_out    <= '0;
            m0_done        <= 1'b0;
            m1_done        <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!c_busy && (m0_req || m1_req)) begin
                        grant_reg      <= next_grant;
                        last_grant_reg <= next_grant;
                        c_address      <= next_grant ? m1_address : m0_address;
                        c_data_in      <= next_grant ? m1_data_in : m0_data_in;
                        c_write_enable <= next_grant ? m1_write_enable : m0_write_enable;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (complete) begin
                        if (c_write_enable == 4'b0000) begin
                            if (grant_reg) begin
                                m1_data_out <= c_data_out;
                            end else begin
                                m0_data_out <= c_data_out;
                            end
                        end
                        // Done is raised here so it is visible for the whole DONE cycle.
                        if (grant_reg) begin
                            m1_done <= 1'b1;
                        end else begin
                            m0_done <= 1'b1;
                        end
                        c_write_enable <= 4'b0000;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
